dma_read_engine: RTL

Responder for the DMA read command/status channel. It accepts one chunk command (address, byte count) from the read-side splitter and issues a single AXI4 INCR read burst. It forwards the returned beats onto a byte-masked data stream toward the write engine, then posts one 2-bit completion status back to the splitter. Exactly one command is in flight at a time.

---
 rtl/dma_read_engine_pkg.sv | 44 ++++
 rtl/dma_keep_gen.sv | 23 ++
 rtl/dma_read_engine.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/dma_read_engine_pkg.sv
// Shared types and constants for the DMA read engine.
// Latency: none (declarations only).
// Backpressure: n/a.
//
// Contents: completion status codes, AXI burst/response encodings, the
// read-engine state enum, the command payload struct and a helper that
// folds two status codes together by severity.
package dma_read_engine_pkg;

  // Completion status posted back to the splitter
  localparam logic [1:0] STAT_OK     = 2'b00;
  localparam logic [1:0] STAT_SLVERR = 2'b01;
  localparam logic [1:0] STAT_BADCMD = 2'b10;
  localparam logic [1:0] STAT_DECERR = 2'b11;

  // AXI4 encodings
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Widest address the command payload can carry
  localparam int CMD_ADDR_MAX_W = 64;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ADDR,
    RD_DATA,
    RD_STAT
  } rd_state_t;

  // Command payload from the read-side splitter
  typedef struct packed {
    logic [CMD_ADDR_MAX_W-1:0] addr;
    logic [31:0]               num_bytes;
  } TransCmd_t;

  // Sticky severity merge: DECERR dominates SLVERR, which dominates OK.
  function automatic logic [1:0] stat_merge(input logic [1:0] a, input logic [1:0] b);
    if (a == STAT_DECERR || b == STAT_DECERR) return STAT_DECERR;
    if (a == STAT_SLVERR || b == STAT_SLVERR) return STAT_SLVERR;
    return STAT_OK;
  endfunction

endpackage

// File: rtl/dma_keep_gen.sv
// Byte-enable mask for the final beat of a chunk.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports:
//   i_rem  - chunk length modulo beat size (low address bits of NumBytes)
//   o_keep - low i_rem bytes set; all ones when i_rem is zero (full beat)
module dma_keep_gen #(
  parameter int BEAT_BYTES = 8,
  parameter int REM_W      = 3
) (
  input  logic [REM_W-1:0]      i_rem,
  output logic [BEAT_BYTES-1:0] o_keep
);

  always_comb begin
    o_keep = '0;
    for (int b = 0; b < BEAT_BYTES; b++) begin
      o_keep[b] = (i_rem == '0) || (REM_W'(b) < i_rem);
    end
  end

endmodule

// File: rtl/dma_read_engine.sv
// One-command-at-a-time DMA read responder: command -> one AXI4 INCR burst -> byte-masked stream -> status.
// Latency: command accept to ARVALID 1 cycle; RDATA to DOutData 0 cycles (combinational pass-through).
// Backpressure: DOutReady drives RREADY directly; no new command until the status handshake completes.
//
// Ports:
//   ACLK, ARESET                       clock, synchronous active-high reset
//   CmdValid/CmdReady/CmdAddr/CmdNumBytes   chunk command from the splitter
//   StatValid/StatReady/StatCode       completion status to the splitter
//   AR*                                AXI4 read address channel (master side)
//   R*                                 AXI4 read data channel (master side)
//   DOut*                              data stream toward the write engine
module dma_read_engine
  import dma_read_engine_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 32,
  parameter int MAX_BEATS = 256
) (
  input  logic                ACLK,
  input  logic                ARESET,
  // command
  input  logic                CmdValid,
  output logic                CmdReady,
  input  logic [ADDR_W-1:0]   CmdAddr,
  input  logic [31:0]         CmdNumBytes,
  // status
  output logic                StatValid,
  input  logic                StatReady,
  output logic [1:0]          StatCode,
  // AXI read address
  output logic [ADDR_W-1:0]   ARADDR,
  output logic [7:0]          ARLEN,
  output logic [2:0]          ARSIZE,
  output logic [1:0]          ARBURST,
  output logic                ARVALID,
  input  logic                ARREADY,
  // AXI read data
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP,
  input  logic                RLAST,
  input  logic                RVALID,
  output logic                RREADY,
  // output stream
  output logic [DATA_W-1:0]   DOutData,
  output logic [DATA_W/8-1:0] DOutKeep,
  output logic                DOutLast,
  output logic                DOutValid,
  input  logic                DOutReady
);

  localparam int          BEAT_BYTES = DATA_W / 8;
  localparam int          BEAT_LSB   = $clog2(BEAT_BYTES);
  localparam logic [31:0] MAX_BYTES  = 32'(MAX_BEATS * BEAT_BYTES);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  rd_state_t             r_state;
  rd_state_t             w_state_nxt;
  logic                  r_arvalid;
  logic [ADDR_W-1:0]     r_araddr;
  logic [7:0]            r_arlen;
  logic [7:0]            r_cnt;       // beats remaining after the current one
  logic [1:0]            r_err;       // running severity for this burst
  logic [1:0]            r_stat;
  logic [BEAT_BYTES-1:0] r_keep_last;

  // ---------------------------------------------------------------------------
  // Command decode
  // ---------------------------------------------------------------------------
  TransCmd_t             w_cmd;
  logic                  w_cmd_fire;
  logic                  w_cmd_bad;
  logic [32:0]           w_beats;
  logic [7:0]            w_arlen_nxt;
  logic [BEAT_BYTES-1:0] w_keep_last;

  assign w_cmd.addr      = CMD_ADDR_MAX_W'(CmdAddr);
  assign w_cmd.num_bytes = CmdNumBytes;

  assign w_cmd_fire = (r_state == RD_IDLE) && CmdValid;

  // Range check happens on the full 32-bit length, so oversize commands are
  // rejected before ARLEN ever gets truncated to 8 bits.
  assign w_cmd_bad = (w_cmd.num_bytes == 32'd0)
                  || (w_cmd.num_bytes > MAX_BYTES)
                  || (w_cmd.addr[BEAT_LSB-1:0] != '0);

  // 33-bit sum so a near-max length cannot wrap before the shift
  assign w_beats     = ({1'b0, w_cmd.num_bytes} + 33'(BEAT_BYTES - 1)) >> BEAT_LSB;
  assign w_arlen_nxt = 8'(w_beats - 33'd1);

  dma_keep_gen #(
    .BEAT_BYTES (BEAT_BYTES),
    .REM_W      (BEAT_LSB)
  ) u_keep_gen (
    .i_rem  (w_cmd.num_bytes[BEAT_LSB-1:0]),
    .o_keep (w_keep_last)
  );

  // ---------------------------------------------------------------------------
  // Burst bookkeeping
  // ---------------------------------------------------------------------------
  logic       w_ar_fire;
  logic       w_beat_fire;
  logic       w_cnt_zero;
  logic [1:0] w_resp_sev;
  logic       w_rlast_bad;
  logic [1:0] w_err_nxt;

  assign w_ar_fire   = r_arvalid && ARREADY;
  assign w_beat_fire = (r_state == RD_DATA) && RVALID && DOutReady;
  assign w_cnt_zero  = (r_cnt == 8'd0);

  always_comb begin
    w_resp_sev = STAT_OK;
    case (RRESP)
      RESP_SLVERR: w_resp_sev = STAT_SLVERR;
      RESP_DECERR: w_resp_sev = STAT_DECERR;
      default:     w_resp_sev = STAT_OK;
    endcase
  end

  // The beat counter decides completion; a misplaced RLAST only taints status.
  assign w_rlast_bad = (RLAST != w_cnt_zero);
  assign w_err_nxt   = stat_merge(stat_merge(r_err, w_resp_sev),
                                  w_rlast_bad ? STAT_SLVERR : STAT_OK);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= RD_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and combinational outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    CmdReady    = 1'b0;
    StatValid   = 1'b0;
    RREADY      = 1'b0;
    DOutValid   = 1'b0;
    DOutData    = '0;
    DOutKeep    = '0;
    DOutLast    = 1'b0;
    case (r_state)
      RD_IDLE: begin
        CmdReady = 1'b1;
        if (CmdValid) begin
          w_state_nxt = w_cmd_bad ? RD_STAT : RD_ADDR;
        end
      end
      RD_ADDR: begin
        if (w_ar_fire) begin
          w_state_nxt = RD_DATA;
        end
      end
      RD_DATA: begin
        DOutValid = RVALID;
        DOutData  = RDATA;
        RREADY    = DOutReady;
        DOutLast  = w_cnt_zero;
        DOutKeep  = w_cnt_zero ? r_keep_last : '1;
        if (w_beat_fire && w_cnt_zero) begin
          w_state_nxt = RD_STAT;
        end
      end
      RD_STAT: begin
        StatValid = 1'b1;
        // Going back to IDLE here means CmdReady only rises next cycle.
        if (StatReady) begin
          w_state_nxt = RD_IDLE;
        end
      end
      default: w_state_nxt = RD_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_arvalid   <= 1'b0;
      r_araddr    <= '0;
      r_arlen     <= '0;
      r_cnt       <= '0;
      r_err       <= STAT_OK;
      r_stat      <= STAT_OK;
      r_keep_last <= '0;
    end else begin
      if (w_cmd_fire) begin
        if (w_cmd_bad) begin
          r_stat <= STAT_BADCMD;
        end else begin
          r_arvalid   <= 1'b1;
          r_araddr    <= ADDR_W'(w_cmd.addr);
          r_arlen     <= w_arlen_nxt;
          r_keep_last <= w_keep_last;
        end
      end
      if (w_ar_fire) begin
        r_arvalid <= 1'b0;
        r_cnt     <= r_arlen;
        r_err     <= STAT_OK;
      end
      if (w_beat_fire) begin
        r_cnt <= r_cnt - 8'd1;
        r_err <= w_err_nxt;
        if (w_cnt_zero) begin
          r_stat <= w_err_nxt;
        end
      end
    end
  end

  assign ARVALID  = r_arvalid;
  assign ARADDR   = r_araddr;
  assign ARLEN    = r_arlen;
  assign ARSIZE   = 3'(BEAT_LSB);
  assign ARBURST  = BURST_INCR;
  assign StatCode = r_stat;

endmodule
